// File: rtl/msk_g16_pkg.sv
// msk_g16_pkg: shared definitions for the masked GF(16) datapath.
//
// A masked GF(16) element with d shares is packed as {x3, x2, x1, x0}. Each xk is
// d bits wide and holds the d shares of GF bit k, so the whole sharing is 4*d bits.
// The helpers below work on a sharing zero-extended to MaxShares shares.
package msk_g16_pkg;

    localparam int unsigned GfBits    = 4;
    localparam int unsigned MaxShares = 8;
    localparam int unsigned MaxShW    = GfBits * MaxShares;

    // Fresh random bits consumed by one DOM multiplication.
    function automatic int unsigned n_rnd_of(input int unsigned shares);
        return GfBits * shares * (shares - 1) / 2;
    endfunction

    // Width of one packed sharing.
    function automatic int unsigned sh_width(input int unsigned shares);
        return GfBits * shares;
    endfunction

    // Returns the d shares of GF bit k. Shares are never XORed together here.
    function automatic logic [MaxShares-1:0] unpack_bit(input logic [MaxShW-1:0] x,
                                                        input int unsigned shares,
                                                        input int unsigned k);
        logic [MaxShares-1:0] low_mask;
        low_mask = (MaxShares'(1) << shares) - MaxShares'(1);
        return MaxShares'(x >> (k * shares)) & low_mask;
    endfunction

    // Writes the d shares of GF bit k into a packed sharing.
    function automatic logic [MaxShW-1:0] pack_bit(input logic [MaxShW-1:0] x,
                                                   input int unsigned shares,
                                                   input int unsigned k,
                                                   input logic [MaxShares-1:0] s);
        logic [MaxShW-1:0] low_mask;
        logic [MaxShW-1:0] field;
        low_mask = (MaxShW'(1) << shares) - MaxShW'(1);
        field    = low_mask << (k * shares);
        return (x & ~field) | ((MaxShW'(s) & low_mask) << (k * shares));
    endfunction

endpackage

// File: rtl/msk_rsp_fifo2.sv
// msk_rsp_fifo2: two-entry result FIFO for the shared masked multiplier.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (empties FIFO, clears storage)
//   push, push_data     write one entry; ignored when full and not popping
//   pop                 drop the head entry; ignored when empty
//   valid, head         head entry, taken straight from storage registers
//   cnt                 number of stored entries (0..2)
// Simultaneous push and pop are both honoured, including when full.
module msk_rsp_fifo2 #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [Width-1:0] head,
    output logic [1:0]       cnt
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (cnt_q != 2'd0);
    // Full is fine to write when the head leaves in the same cycle.
    assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign valid = (cnt_q != 2'd0);
    assign head  = mem_q[rd_ptr_q];
    assign cnt   = cnt_q;

endmodule

// File: rtl/msk_g16mul_sched.sv
// msk_g16mul_sched: round-robin sharing of one masked GF(16) DOM multiplier
// (latency 1) between N_REQ requesters.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           per-requester handshake; req_ready is the one-hot grant
//   req_a, req_b                  requester i operands at [i*4*d +: 4*d], layout {x3..x0}
//   rnd_valid/rnd_ready, rnd_in   fresh randomness, one word consumed per issue
//   mul_ina, mul_inb, mul_rnd     multiplier inputs, all-zero on idle cycles
//   mul_out                       multiplier result, one cycle after issue
//   rsp_valid/rsp_ready           result handshake, in issue order
//   rsp_id, rsp_data              requester index and masked product
//
// At most two results are ever outstanding (one in flight plus the FIFO), so the
// two-entry FIFO can always take the multiplier output and needs no stall path.
module msk_g16mul_sched
    import msk_g16_pkg::*;
#(
    parameter int unsigned d     = 2,
    parameter int unsigned N_REQ = 4,
    localparam int unsigned n_rnd = n_rnd_of(d),
    localparam int unsigned ShW   = sh_width(d),
    localparam int unsigned IdW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*ShW-1:0] req_a,
    input  logic [N_REQ*ShW-1:0] req_b,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [n_rnd-1:0]     rnd_in,
    output logic [ShW-1:0]       mul_ina,
    output logic [ShW-1:0]       mul_inb,
    output logic [n_rnd-1:0]     mul_rnd,
    input  logic [ShW-1:0]       mul_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IdW-1:0]       rsp_id,
    output logic [ShW-1:0]       rsp_data
);

    localparam int unsigned EntW = IdW + ShW;

    logic [IdW-1:0]   rr_q;
    logic             inflight_q;
    logic [IdW-1:0]   inflight_id_q;

    logic [N_REQ-1:0] cand;
    logic [IdW-1:0]   cand_idx;
    logic             found;
    logic [IdW:0]     pos;
    logic [IdW-1:0]   rr_next;

    logic [N_REQ-1:0] gnt;
    logic             issue;
    logic             pop;
    logic [1:0]       fifo_cnt;
    logic [2:0]       occ;
    logic [EntW-1:0]  fifo_head;

    // Cyclic search for the first valid requester at or after rr_q.
    always_comb begin
        cand     = '0;
        cand_idx = '0;
        found    = 1'b0;
        pos      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_q} + (IdW + 1)'(k);
            if (pos >= (IdW + 1)'(N_REQ)) begin
                pos = pos - (IdW + 1)'(N_REQ);
            end
            if (!found && req_valid[pos[IdW-1:0]]) begin
                found               = 1'b1;
                cand[pos[IdW-1:0]]  = 1'b1;
                cand_idx            = pos[IdW-1:0];
            end
        end
    end

    assign rr_next = (cand_idx == IdW'(N_REQ - 1)) ? '0 : cand_idx + IdW'(1);

    // Outstanding results after this cycle's pop; inflight + fifo_cnt never exceeds 2.
    assign pop   = rsp_valid && rsp_ready;
    assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = !rst && found && rnd_valid && (occ < 3'd2);

    // Grant and randomness are both gated by issue, so operands only reach the
    // multiplier together with a fresh, just-consumed randomness word.
    assign gnt       = cand & {N_REQ{issue}};
    assign req_ready = gnt;
    assign rnd_ready = issue;
    assign mul_rnd   = rnd_in & {n_rnd{issue}};

    // Per-share AND-OR select driven by the one-hot grant; shares are never combined.
    always_comb begin
        mul_ina = '0;
        mul_inb = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            mul_ina = mul_ina | (req_a[i*ShW +: ShW] & {ShW{gnt[i]}});
            mul_inb = mul_inb | (req_b[i*ShW +: ShW] & {ShW{gnt[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                rr_q          <= rr_next;
                inflight_id_q <= cand_idx;
            end
        end
    end

    // The multiplier output is only meaningful the cycle after an issue; reset drops it.
    msk_rsp_fifo2 #(
        .Width (EntW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_id_q, mul_out}),
        .pop       (pop),
        .valid     (rsp_valid),
        .head      (fifo_head),
        .cnt       (fifo_cnt)
    );

    assign rsp_id   = fifo_head[ShW +: IdW];
    assign rsp_data = fifo_head[ShW-1:0];

endmodule

// File: doc/msk_g16mul_sched.md
# msk_g16mul_sched

Round-robin scheduler that shares one masked GF(16) DOM multiplier (`MSKg16mul_dom`, latency 1) between `N_REQ` requesters inside the masked S-box datapath. It issues at most one multiplication per cycle and feeds exactly one fresh randomness word per issue from a valid/ready randomness source. It drives the multiplier inputs to all-zero on idle cycles. Results come back in issue order through a 2-entry result FIFO, tagged with the requester index.

## Interface
- `d`, 2, number of shares
- `N_REQ`, 4, number of requesters (2..8)
- `n_rnd` (localparam), 4*d*(d-1)/2, random bits per multiplication
- `clk  in  1  single clock, all state on rising edge`
- `rst  in  1  reset, synchronous, active-high`
- `req_valid  in  N_REQ  requester i has an operand pair`
- `req_ready  out  N_REQ  one-hot grant; high on the issue cycle only`
- `req_a  in  N_REQ*4*d  operand a of requester i at [i*4*d +: 4*d]; sharing layout {a3,a2,a1,a0}, each ak d bits`
- `req_b  in  N_REQ*4*d  operand b, same layout`
- `rnd_valid  in  1  fresh randomness available`
- `rnd_ready  out  1  randomness consumed this cycle`
- `rnd_in  in  n_rnd  randomness word`
- `mul_ina  out  4*d  to multiplier {ina3,ina2,ina1,ina0}`
- `mul_inb  out  4*d  to multiplier {inb3..inb0}`
- `mul_rnd  out  n_rnd  to multiplier rnd`
- `mul_out  in  4*d  from multiplier {out3..out0}`
- `rsp_valid  out  1  result available`
- `rsp_ready  in  1  consumer accepts result`
- `rsp_id  out  clog2(N_REQ)  requester index of result`
- `rsp_data  out  4*d  masked product, same layout`

## Operation
- Issue condition: `any(req_valid) && rnd_valid && (inflight + fifo_cnt - pop) < 2`, where `pop = rsp_valid && rsp_ready`.
- On issue:
  - grant g = first requester with valid at or after `rr_ptr`, cyclic search.
  - `req_ready[g]=1`, `rnd_ready=1`.
  - `mul_ina`/`mul_inb` take requester g's operands; `mul_rnd = rnd_in`.
  - Next cycle: `rr_ptr <= (g+1) mod N_REQ`, `inflight <= 1`, `inflight_id <= g`.
- No issue: `mul_ina`, `mul_inb`, `mul_rnd` are all-zero; `req_ready=0`, `rnd_ready=0`; `inflight <= 0`.
- Masking rules:
  - A randomness word is never applied to two multiplications.
  - Operands are never presented to the multiplier without a granted randomness word.
  - No share recombination anywhere; all muxing is per-share AND-OR, driven by one-hot grant.
- When `inflight=1`: `mul_out` is pushed into the FIFO with `inflight_id` in the same cycle.
- FIFO head drives `rsp_*`; pop and push in the same cycle are both honored.
- Register state: `rr_ptr`, `inflight`, `inflight_id`, 2 FIFO entries, `fifo_cnt` (0..2), FIFO pointers.

## Timing
- Latency: issue in cycle t → FIFO push at t+1 → `rsp_valid` at t+2 (FIFO empty case).
- Throughput: 1 issue/cycle sustained while `rsp_ready=1` and `rnd_valid=1`.
- Backpressure: with `rsp_ready=0`, at most 2 results are outstanding (FIFO full, or 1 in FIFO + 1 inflight); further issue stalls.
- `rnd_valid=0` stalls issue; no partial grant is made.
- Reset values (cycle after `rst` high), and held while `rst` high:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`
  - `req_ready=0`, `rnd_ready=0`
  - `mul_*=0`
  - `rr_ptr=0`, `inflight=0`, FIFO empty
- Reset mid-operation: the in-flight result is dropped; FIFO contents are discarded.
- Outputs `req_ready`, `rnd_ready`, `mul_*` are combinational from inputs and state. `rsp_*` are registered (FIFO head).

## Structure
- Shared package `msk_g16_pkg`: `n_rnd` function of d, GF(16) sharing width 4*d, pack/unpack helpers for {x3..x0} share layout.
- One sub-module natural: `msk_rsp_fifo2`, a 2-entry FIFO (data width 4*d + id width) with push/pop/cnt.
- Round-robin arbiter stays inline (small, one-hot output).

## Test plan
- d=2, N_REQ=4, requester 2 only, rnd stream 0x1,0x2,…, `rsp_ready=1`:
  - `req_ready[2]` in cycle t, `rsp_valid` at t+2, `rsp_id=2`.
  - Recombined `rsp_data` equals golden G16 product.
  - `mul_*` zero in all other cycles.
- All 4 requesters valid continuously: grants 0,1,2,3,0,… one per cycle; `rsp_id` sequence identical; each `rnd_in` word consumed once.
- `rsp_ready=0` with all requesters valid: exactly 2 issues, then `req_ready=0`. After `rsp_ready=1`: results pop in order, issue resumes the next cycle.
- `rnd_valid` toggling 1,0,1,0: issues only in `rnd_valid=1` cycles; `mul_*` zero on others.
- `rst` asserted the cycle after an issue:
  - No `rsp_valid` ever appears for that operand.
  - Next grant after reset goes to requester 0 when all are valid.
- Masking check: random sharings of a=0x5, b=0xB over 1000 issues. Every `rsp_data` recombines to the golden product; individual shares are non-constant.
